// File: rtl/tow_referee.sv
// Tug-of-war referee: reads the arbitration latch, steps the rope marker, re-arms the latch, declares a winner.
// Latency: a push sampled at edge k updates leds/moves/win flags/clr after edge k+1. All outputs are registered.
// Backpressure: none. Presses outside IDLE are ignored, and clr holds the latch disarmed until both buttons stay released.
module tow_referee #(
  parameter int NLEDS = 9,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             tie,
  input  logic             right,
  input  logic             pbl,
  input  logic             pbr,
  output logic             clr,
  output logic [NLEDS-1:0] leds,
  output logic             winl,
  output logic             winr,
  output logic [7:0]       moves
);

  localparam int PW = $clog2(NLEDS);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [PW-1:0] CENTRE   = PW'((NLEDS - 1) / 2);
  localparam logic [PW-1:0] TOP      = PW'(NLEDS - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(HOLD - 1);

  typedef enum logic [1:0] {
    S_CLEAR  = 2'd0,
    S_IDLE   = 2'd1,
    S_DECIDE = 2'd2,
    S_WIN    = 2'd3
  } state_t;

  state_t          state, state_nxt;
  logic [PW-1:0]   pos, pos_nxt;
  logic [CW-1:0]   cnt, cnt_nxt;
  logic [7:0]      moves_nxt;
  logic            winl_nxt, winr_nxt;
  logic            clr_nxt;

  // Next-state and datapath updates; every register holds unless a state rule changes it.
  always_comb begin
    state_nxt = state;
    pos_nxt   = pos;
    cnt_nxt   = cnt;
    moves_nxt = moves;
    winl_nxt  = winl;
    winr_nxt  = winr;
    case (state)
      S_CLEAR: begin
        if (pbl | pbr) begin
          cnt_nxt = '0;
        end else if (cnt == CNT_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_IDLE: begin
        // One cycle of slack in DECIDE lets a late second press show up as tie.
        if (push) state_nxt = S_DECIDE;
      end
      S_DECIDE: begin
        cnt_nxt   = '0;
        state_nxt = S_CLEAR;
        if (!tie) begin
          pos_nxt = right ? (pos + 1'b1) : (pos - 1'b1);
          if (moves != 8'hFF) moves_nxt = moves + 8'd1;
          if (pos_nxt == TOP) begin
            winr_nxt  = 1'b1;
            state_nxt = S_WIN;
          end else if (pos_nxt == '0) begin
            winl_nxt  = 1'b1;
            state_nxt = S_WIN;
          end
        end
      end
      S_WIN: begin
        state_nxt = S_WIN;
      end
      default: begin
        state_nxt = S_CLEAR;
      end
    endcase
    // The latch is only armed while waiting for or resolving a press.
    clr_nxt = !((state_nxt == S_IDLE) || (state_nxt == S_DECIDE));
  end

  // State and output registers, all cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_CLEAR;
      pos   <= CENTRE;
      cnt   <= '0;
      moves <= 8'd0;
      winl  <= 1'b0;
      winr  <= 1'b0;
      clr   <= 1'b1;
      leds  <= NLEDS'(1) << CENTRE;
    end else begin
      state <= state_nxt;
      pos   <= pos_nxt;
      cnt   <= cnt_nxt;
      moves <= moves_nxt;
      winl  <= winl_nxt;
      winr  <= winr_nxt;
      clr   <= clr_nxt;
      leds  <= NLEDS'(1) << pos_nxt;
    end
  end

endmodule

// File: tb/tb_tow_referee.sv
// Randomised bench for tow_referee with a rule-level reference model and a per-cycle scoreboard.
// Expectations are queued at each rising edge and checked at the following falling edge.
// Directed checks cover reset timing, bounce, asynchronous reset, win freeze and move saturation.
module tb_tow_referee;

  localparam int NLEDS = 9;
  localparam int HOLD  = 4;
  localparam int CTR   = (NLEDS - 1) / 2;

  logic             clk = 1'b0;
  logic             rst;
  logic             push, tie, right, pbl, pbr;
  logic             clr;
  logic [NLEDS-1:0] leds;
  logic             winl, winr;
  logic [7:0]       moves;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {
    logic             clr;
    logic [NLEDS-1:0] leds;
    logic             winl;
    logic             winr;
    logic [7:0]       moves;
  } exp_t;

  exp_t exp_q[$];

  tow_referee #(.NLEDS(NLEDS), .HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .push(push), .tie(tie), .right(right),
    .pbl(pbl), .pbr(pbr), .clr(clr), .leds(leds),
    .winl(winl), .winr(winr), .moves(moves)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the game described as rules, not as a state encoding.
  int m_pos, m_moves, m_streak;
  bit m_armed, m_pending, m_won, m_winl, m_winr, m_clr;

  function automatic exp_t snap();
    exp_t e;
    e.clr   = m_clr;
    e.leds  = NLEDS'(1) << m_pos;
    e.winl  = m_winl;
    e.winr  = m_winr;
    e.moves = 8'(m_moves);
    return e;
  endfunction

  task automatic m_reset();
    m_pos = CTR; m_moves = 0; m_streak = 0;
    m_armed = 0; m_pending = 0; m_won = 0;
    m_winl = 0; m_winr = 0; m_clr = 1;
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reset();
      exp_q.delete();
      exp_q.push_back(snap());
    end else begin
      if (m_won) begin
        // game over: nothing moves
      end else if (m_pending) begin
        m_pending = 0;
        m_clr = 1;
        m_streak = 0;
        if (!tie) begin
          m_pos = m_pos + (right ? 1 : -1);
          m_moves = (m_moves < 255) ? m_moves + 1 : 255;
          if (m_pos == NLEDS - 1) begin m_winr = 1; m_won = 1; end
          else if (m_pos == 0)    begin m_winl = 1; m_won = 1; end
        end
      end else if (m_armed) begin
        if (push) begin m_armed = 0; m_pending = 1; end
      end else begin
        if (pbl || pbr) m_streak = 0;
        else begin
          m_streak++;
          if (m_streak == HOLD) begin m_armed = 1; m_clr = 0; m_streak = 0; end
        end
      end
      exp_q.push_back(snap());
    end
  end

  // Monitor: outputs are valid every cycle; compare against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("clr",   32'(clr),   32'(e.clr));
      chk("leds",  32'(leds),  32'(e.leds));
      chk("winl",  32'(winl),  32'(e.winl));
      chk("winr",  32'(winr),  32'(e.winr));
      chk("moves", 32'(moves), 32'(e.moves));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_armed(output bit ok);
    ok = 0;
    for (int i = 0; i < 60; i++) begin
      if (clr === 1'b0) begin ok = 1; break; end
      tick();
    end
    if (!ok) chk("arm_timeout", 32'(clr), 32'(0));
  endtask

  // One pull: latch result at edge k, tie may appear at edge k+1, buttons held then released.
  task automatic pull(input bit r, input bit t, input int hold, input bit bounce);
    bit ok;
    wait_armed(ok);
    if (!ok) return;
    push = 1; right = r; pbr = r; pbl = !r;
    tick();
    if (t) begin tie = 1; right = 1; pbl = 1; pbr = 1; end
    tick();
    push = 0; tie = 0; right = 0;
    repeat (hold) tick();
    pbl = 0; pbr = 0;
    if (bounce) begin
      tick();
      pbl = 1; push = 1;
      tick();
      pbl = 0; push = 0;
    end
  endtask

  task automatic do_reset();
    rst = 0;
    tick(); tick();
    rst = 1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    bit [6:0] pat;
    rst = 0; push = 0; tie = 0; right = 0; pbl = 0; pbr = 0;
    tick(); tick(); tick();
    rst = 1;
    // Reset state and re-arm timing.
    chk("rst_leds", 32'(leds), 32'(9'b000010000));
    chk("rst_moves", 32'(moves), 32'(0));
    tick(); tick(); tick();
    chk("rst_clr_hold", 32'(clr), 32'(1));
    tick();
    chk("rst_clr_fall", 32'(clr), 32'(0));

    // Single right pull, then a tie pull.
    pull(1, 0, 3, 0);
    chk("right_leds", 32'(leds), 32'(9'b000100000));
    chk("right_moves", 32'(moves), 32'(1));
    pull(0, 1, 1, 0);
    chk("tie_leds", 32'(leds), 32'(9'b000100000));
    chk("tie_moves", 32'(moves), 32'(1));
    chk("tie_clr", 32'(clr), 32'(1));

    // Left pull followed by a bouncing left button during re-arm.
    pull(0, 0, 0, 0);
    pat = 7'b0000100;
    for (int i = 0; i < 7; i++) begin
      pbl = pat[i];
      if (i == 6) chk("bounce_clr_hold", 32'(clr), 32'(1));
      tick();
    end
    chk("bounce_clr_fall", 32'(clr), 32'(0));
    pbl = 0;

    // Asynchronous reset while a press is being decided.
    wait_armed(ok);
    push = 1; right = 1; pbr = 1;
    tick();
    #2 rst = 0;
    #1;
    chk("arst_clr", 32'(clr), 32'(1));
    chk("arst_leds", 32'(leds), 32'(9'b000010000));
    chk("arst_moves", 32'(moves), 32'(0));
    chk("arst_win", 32'({winl, winr}), 32'(0));
    push = 0; right = 0; pbr = 0;
    tick(); tick();
    rst = 1;

    // Four left pulls win for the left player; the game then stays frozen.
    for (int i = 0; i < 4; i++) pull(0, 0, 1, 0);
    chk("winl_leds", 32'(leds), 32'(9'b000000001));
    chk("winl_flag", 32'({winl, winr}), 32'(2'b10));
    for (int i = 0; i < 20; i++) begin
      push = 1'($urandom); right = 1'($urandom); tie = 1'($urandom);
      pbl = 1'($urandom); pbr = 1'($urandom);
      tick();
    end
    push = 0; right = 0; tie = 0; pbl = 0; pbr = 0;
    chk("frozen_leds", 32'(leds), 32'(9'b000000001));
    chk("frozen_moves", 32'(moves), 32'(4));
    chk("frozen_clr", 32'(clr), 32'(1));

    // Alternating pulls saturate the move counter without a winner.
    do_reset();
    for (int i = 0; i < 300; i++) pull(i % 2 == 0, 0, $urandom_range(0, 2), 0);
    chk("sat_moves", 32'(moves), 32'(255));
    chk("sat_nowin", 32'({winl, winr}), 32'(0));

    // Random games until someone wins.
    for (int g = 0; g < 4; g++) begin
      do_reset();
      for (int p = 0; p < 60 && !(winl || winr); p++)
        pull(1'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 3), $urandom_range(0, 3) == 0);
      repeat (3) tick();
    end

    tick(); tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
